bram_write_dist: RTL and testbench
==================================

BRAM_WRITE_DIST -- requirements
Module: bram_write_dist

Interface
REQ-001 Parameter N_BANK, default 420: number of BRAM banks; legal range N_CH < N_BANK <= 512.
REQ-002 Parameter N_CH, default 16: number of write channels; legal range 1..N_BANK-1.
REQ-003 Parameter DW, default 33: data width per write.
REQ-004 Parameter AW, default 6: bank address width; bank depth is 2^AW.
REQ-005 Parameter IW, default 9: bank index width; 2^IW >= N_BANK.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 r_reset_n  in  1  reset, asynchronous, active-low.
REQ-008 clr  in  1  synchronous clear of pointers, addresses, full flags and sticky errors.
REQ-009 stride_mode  in  1  pointer step select: 0 = step 1, 1 = step N_CH.
REQ-010 wr_req  in  N_CH  per-channel write request.
REQ-011 wr_data  in  N_CH*DW  per-channel data; channel c occupies bits [c*DW +: DW].
REQ-012 wr_ack  out  N_CH  per-channel acceptance, registered.
REQ-013 bank_we  out  N_BANK  per-bank write enable, registered.
REQ-014 bank_addr  out  N_BANK*AW  per-bank write address, registered.
REQ-015 bank_din  out  N_BANK*DW  per-bank write data, registered.
REQ-016 bank_full  out  N_BANK  bank has received 2^AW writes.
REQ-017 all_full  out  1  AND of bank_full.
REQ-018 err_conflict  out  1  sticky; set by a lost bank arbitration.
REQ-019 err_overflow  out  1  sticky; set by a request to a full bank.

Function
REQ-020 Each channel c SHALL hold an IW-bit pointer ptr[c], initialised to c.
REQ-021 Each bank b SHALL hold an AW-bit address counter addr[b], initialised to 0.
REQ-022 Channel c is eligible when wr_req[c]=1 and bank_full[ptr[c]]=0.
REQ-023 Arbitration: when several eligible channels share a pointer value, the lowest channel index wins; the others lose.
REQ-024 Winning channel c in cycle t SHALL produce, at edge t+1: wr_ack[c]=1, bank_we[ptr[c]]=1, bank_addr of that bank = addr[ptr[c]] before the increment, bank_din of that bank = wr_data[c].
REQ-025 On a win, addr[ptr[c]] SHALL increment by 1; when the pre-increment value is 2^AW-1, bank_full[ptr[c]] SHALL set and addr SHALL wrap to 0.
REQ-026 On a win, ptr[c] SHALL advance by step S (1 or N_CH, selected by stride_mode); when ptr+S >= N_BANK, the result SHALL be ptr+S-N_BANK. Sums SHALL be computed at IW+1 bits.
REQ-027 A losing or non-eligible channel SHALL keep its pointer, and its wr_ack SHALL be 0 the following cycle.
REQ-028 A lost arbitration SHALL set err_conflict.
REQ-029 A request to a full bank SHALL set err_overflow; that write SHALL be dropped.
REQ-030 Sticky errors SHALL clear only on reset or clr.
REQ-031 bank_we, wr_ack, bank_addr and bank_din SHALL be single-cycle pulses and values; bank_we=0 and bank_addr, bank_din hold in cycles without a win.
REQ-032 A stride_mode change SHALL affect only pointer advances from the next win onward; pointers are not re-aligned.
REQ-033 clr=1 SHALL take priority over any request in the same cycle: no ack, no bank_we.
REQ-034 After clr, all registers SHALL hold their reset values at the next edge.

Reset
REQ-035 Asynchronous reset assertion SHALL immediately set: ptr[c]=c, addr=0, bank_full=0, all_full=0, wr_ack=0, bank_we=0, bank_addr=0, bank_din=0, err_conflict=0, err_overflow=0.
REQ-036 Reset mid-operation SHALL discard any in-flight write; no bank_we pulse SHALL appear on deassertion.
REQ-037 Operation SHALL resume on the first rising edge after r_reset_n deasserts.

Verification
(bench parameters: N_BANK=8, N_CH=2, AW=2, DW=8)
REQ-038 Reset, then wr_req=2'b11 for one cycle with data 0xA0 (channel 0) and 0xB1 (channel 1) -> next cycle: bank_we[0]=1 with addr 0 and din 0xA0; bank_we[1]=1 with addr 0 and din 0xB1; wr_ack=2'b11; ptr = {2,1}.
REQ-039 stride_mode=0, channel 0 only, 9 consecutive requests -> banks 0..7 then 0 written; final bank 0 write at addr 1; ptr[0]=1.
REQ-040 Reset, stride_mode=0; channel 0 requests once (ptr[0]=1), then channels 0 and 1 request together -> channel 0 wins bank 1; wr_ack=2'b01; err_conflict=1; ptr[1] stays 1.
REQ-041 Channel 0, stride_mode=1, 16 requests -> banks 0,2,4,6 each written 4 times; bank_full=8'h55; 17th request: no ack, err_overflow=1.
REQ-042 Assert r_reset_n low mid-burst and assert clr with wr_req=2'b11 -> all outputs return to reset values; no bank_we pulse; errors cleared.

Source files
------------

// File: rtl/bram_write_dist.sv
// rtl/bram_write_dist.sv - distributes per-channel writes round-robin across BRAM banks
module bram_write_dist #(
  parameter int N_BANK = 420,
  parameter int N_CH   = 16,
  parameter int DW     = 33,
  parameter int AW     = 6,
  parameter int IW     = 9
) (
  input  logic                 clk,
  input  logic                 r_reset_n,
  input  logic                 clr,
  input  logic                 stride_mode,
  input  logic [N_CH-1:0]      wr_req,
  input  logic [N_CH*DW-1:0]   wr_data,
  output logic [N_CH-1:0]      wr_ack,
  output logic [N_BANK-1:0]    bank_we,
  output logic [N_BANK*AW-1:0] bank_addr,
  output logic [N_BANK*DW-1:0] bank_din,
  output logic [N_BANK-1:0]    bank_full,
  output logic                 all_full,
  output logic                 err_conflict,
  output logic                 err_overflow
);

  localparam int BW  = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int IW1 = IW + 1;
  localparam logic [IW:0] NB_W     = IW1'(N_BANK);
  localparam logic [IW:0] STEP_CH  = IW1'(N_CH);
  localparam logic [IW:0] STEP_ONE = IW1'(1);

  logic [IW-1:0]        ptr_q  [N_CH];
  logic [IW-1:0]        ptr_d  [N_CH];
  logic [AW-1:0]        addr_q [N_BANK];
  logic [AW-1:0]        addr_d [N_BANK];
  logic [N_BANK-1:0]    bank_full_q, bank_full_d;
  logic [N_CH-1:0]      wr_ack_q, wr_ack_d;
  logic [N_BANK-1:0]    bank_we_q, bank_we_d;
  logic [N_BANK*AW-1:0] bank_addr_q, bank_addr_d;
  logic [N_BANK*DW-1:0] bank_din_q, bank_din_d;
  logic                 err_conflict_q, err_conflict_d;
  logic                 err_overflow_q, err_overflow_d;

  logic [N_CH-1:0] eligible, win, lose, ovf;

  // Pointer advance with wrap past the last bank; sum kept one bit wider than the pointer
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p, input logic s);
    logic [IW:0] sum;
    sum = {1'b0, p} + (s ? STEP_CH : STEP_ONE);
    if (sum >= NB_W) sum = sum - NB_W;
    return sum[IW-1:0];
  endfunction

  // Eligibility and fixed-priority arbitration: lowest channel wins a shared bank
  always_comb begin
    eligible = '0;
    ovf      = '0;
    win      = '0;
    lose     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_req[c]) begin
        if (bank_full_q[BW'(ptr_q[c])]) ovf[c] = 1'b1;
        else                            eligible[c] = 1'b1;
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      win[c] = eligible[c];
      for (int j = 0; j < c; j++) begin
        if (eligible[j] && (ptr_q[j] == ptr_q[c])) win[c] = 1'b0;
      end
      lose[c] = eligible[c] & ~win[c];
    end
  end

  // Next state: route winners to their banks, bump addresses and pointers; clr overrides all
  always_comb begin
    ptr_d          = ptr_q;
    addr_d         = addr_q;
    bank_full_d    = bank_full_q;
    wr_ack_d       = '0;
    bank_we_d      = '0;
    bank_addr_d    = bank_addr_q;
    bank_din_d     = bank_din_q;
    err_conflict_d = err_conflict_q | (|lose);
    err_overflow_d = err_overflow_q | (|ovf);
    for (int c = 0; c < N_CH; c++) begin
      if (win[c]) begin
        wr_ack_d[c]                                 = 1'b1;
        bank_we_d[BW'(ptr_q[c])]                    = 1'b1;
        bank_addr_d[int'(ptr_q[c])*AW +: AW]        = addr_q[BW'(ptr_q[c])];
        bank_din_d[int'(ptr_q[c])*DW +: DW]         = wr_data[c*DW +: DW];
        addr_d[BW'(ptr_q[c])]                       = addr_q[BW'(ptr_q[c])] + AW'(1);
        if (addr_q[BW'(ptr_q[c])] == '1) bank_full_d[BW'(ptr_q[c])] = 1'b1;
        ptr_d[c]                                    = next_ptr(ptr_q[c], stride_mode);
      end
    end
    if (clr) begin
      for (int c = 0; c < N_CH; c++) ptr_d[c] = IW'(c);
      for (int b = 0; b < N_BANK; b++) addr_d[b] = '0;
      bank_full_d    = '0;
      wr_ack_d       = '0;
      bank_we_d      = '0;
      bank_addr_d    = '0;
      bank_din_d     = '0;
      err_conflict_d = 1'b0;
      err_overflow_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge r_reset_n) begin
    if (!r_reset_n) begin
      for (int c = 0; c < N_CH; c++) ptr_q[c] <= IW'(c);
      for (int b = 0; b < N_BANK; b++) addr_q[b] <= '0;
      bank_full_q    <= '0;
      wr_ack_q       <= '0;
      bank_we_q      <= '0;
      bank_addr_q    <= '0;
      bank_din_q     <= '0;
      err_conflict_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      addr_q         <= addr_d;
      bank_full_q    <= bank_full_d;
      wr_ack_q       <= wr_ack_d;
      bank_we_q      <= bank_we_d;
      bank_addr_q    <= bank_addr_d;
      bank_din_q     <= bank_din_d;
      err_conflict_q <= err_conflict_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign bank_we      = bank_we_q;
  assign bank_addr    = bank_addr_q;
  assign bank_din     = bank_din_q;
  assign bank_full    = bank_full_q;
  assign all_full     = &bank_full_q;
  assign err_conflict = err_conflict_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_bram_write_dist.sv
// tb/tb_bram_write_dist.sv - table-driven bench for bram_write_dist
module tb_bram_write_dist;

  localparam int N_BANK = 8;
  localparam int N_CH   = 2;
  localparam int DW     = 8;
  localparam int AW     = 2;
  localparam int IW     = 3;

  logic                 clk = 1'b0;
  logic                 r_reset_n = 1'b1;
  logic                 clr = 1'b0;
  logic                 stride_mode = 1'b0;
  logic [N_CH-1:0]      wr_req = '0;
  logic [N_CH*DW-1:0]   wr_data = '0;
  logic [N_CH-1:0]      wr_ack;
  logic [N_BANK-1:0]    bank_we;
  logic [N_BANK*AW-1:0] bank_addr;
  logic [N_BANK*DW-1:0] bank_din;
  logic [N_BANK-1:0]    bank_full;
  logic                 all_full;
  logic                 err_conflict;
  logic                 err_overflow;

  bram_write_dist #(.N_BANK(N_BANK), .N_CH(N_CH), .DW(DW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .r_reset_n(r_reset_n), .clr(clr), .stride_mode(stride_mode),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_din(bank_din), .bank_full(bank_full),
    .all_full(all_full), .err_conflict(err_conflict), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       clr;
    bit       stride;
    bit [1:0] req;
    bit [7:0] d0;
    bit [7:0] d1;
    bit [1:0] ack;
    int       wb0;
    int       wa0;
    bit [7:0] wd0;
    int       wb1;
    int       wa1;
    bit [7:0] wd1;
    bit [7:0] full;
    bit       errc;
    bit       erro;
  } vec_t;

  vec_t     vq[$];
  int       n_chk = 0;
  int       n_fail = 0;
  bit [1:0] sh_addr [N_BANK];
  bit [7:0] sh_din  [N_BANK];

  function automatic vec_t mk(bit c, bit s, bit [1:0] rq, bit [7:0] a, bit [7:0] b, bit [1:0] ak,
                              int b0, int a0, bit [7:0] w0, int b1, int a1, bit [7:0] w1,
                              bit [7:0] fu, bit ec, bit eo);
    vec_t v;
    v.clr = c; v.stride = s; v.req = rq; v.d0 = a; v.d1 = b; v.ack = ak;
    v.wb0 = b0; v.wa0 = a0; v.wd0 = w0; v.wb1 = b1; v.wa1 = a1; v.wd1 = w1;
    v.full = fu; v.errc = ec; v.erro = eo;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [N_BANK-1:0]    exp_we;
    logic [N_BANK*AW-1:0] exp_a;
    logic [N_BANK*DW-1:0] exp_d;
    @(negedge clk);
    clr = v.clr; stride_mode = v.stride; wr_req = v.req; wr_data = {v.d1, v.d0};
    @(posedge clk);
    #1;
    if (v.clr) begin
      for (int b = 0; b < N_BANK; b++) begin sh_addr[b] = '0; sh_din[b] = '0; end
    end
    exp_we = '0;
    if (v.wb0 >= 0) begin exp_we[v.wb0] = 1'b1; sh_addr[v.wb0] = 2'(v.wa0); sh_din[v.wb0] = v.wd0; end
    if (v.wb1 >= 0) begin exp_we[v.wb1] = 1'b1; sh_addr[v.wb1] = 2'(v.wa1); sh_din[v.wb1] = v.wd1; end
    for (int b = 0; b < N_BANK; b++) begin
      exp_a[b*AW +: AW] = sh_addr[b];
      exp_d[b*DW +: DW] = sh_din[b];
    end
    chk("wr_ack", idx, 64'(wr_ack), 64'(v.ack));
    chk("bank_we", idx, 64'(bank_we), 64'(exp_we));
    chk("bank_addr", idx, 64'(bank_addr), 64'(exp_a));
    chk("bank_din", idx, 64'(bank_din), 64'(exp_d));
    chk("bank_full", idx, 64'(bank_full), 64'(v.full));
    chk("all_full", idx, 64'(all_full), 64'(&v.full));
    chk("err_conflict", idx, 64'(err_conflict), 64'(v.errc));
    chk("err_overflow", idx, 64'(err_overflow), 64'(v.erro));
  endtask

  task automatic chk_zero(input string tag, input int idx);
    chk({tag, "_ack"}, idx, 64'(wr_ack), 64'h0);
    chk({tag, "_we"}, idx, 64'(bank_we), 64'h0);
    chk({tag, "_addr"}, idx, 64'(bank_addr), 64'h0);
    chk({tag, "_din"}, idx, 64'(bank_din), 64'h0);
    chk({tag, "_full"}, idx, 64'(bank_full), 64'h0);
    chk({tag, "_all_full"}, idx, 64'(all_full), 64'h0);
    chk({tag, "_errc"}, idx, 64'(err_conflict), 64'h0);
    chk({tag, "_erro"}, idx, 64'(err_overflow), 64'h0);
  endtask

  initial begin
    bit [7:0] fu;

    // Two-channel simultaneous writes, then a clr that collides with requests
    vq.push_back(mk(0,0,2'b11,8'hA0,8'hB1,2'b11, 0,0,8'hA0, 1,0,8'hB1, 8'h00,0,0));
    vq.push_back(mk(0,0,2'b11,8'hC2,8'hD3,2'b11, 1,1,8'hC2, 2,0,8'hD3, 8'h00,0,0));
    vq.push_back(mk(1,0,2'b11,8'hAA,8'hBB,2'b00, -1,0,8'h00, -1,0,8'h00, 8'h00,0,0));
    // Shared-pointer conflict: channel 0 wins, channel 1 keeps its pointer
    vq.push_back(mk(0,0,2'b01,8'h11,8'h00,2'b01, 0,0,8'h11, -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(0,0,2'b11,8'h22,8'h33,2'b01, 1,0,8'h22, -1,0,8'h00, 8'h00,1,0));
    vq.push_back(mk(0,0,2'b10,8'h00,8'h44,2'b10, 1,1,8'h44, -1,0,8'h00, 8'h00,1,0));
    vq.push_back(mk(0,0,2'b00,8'h00,8'h00,2'b00, -1,0,8'h00, -1,0,8'h00, 8'h00,1,0));
    vq.push_back(mk(1,0,2'b00,8'h00,8'h00,2'b00, -1,0,8'h00, -1,0,8'h00, 8'h00,0,0));
    // Step-1 walk over all banks and wrap, then stride switch without re-alignment
    for (int i = 0; i < 8; i++)
      vq.push_back(mk(0,0,2'b01,8'(8'h50+i),8'h00,2'b01, i,0,8'(8'h50+i), -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(0,0,2'b01,8'h58,8'h00,2'b01, 0,1,8'h58, -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(0,0,2'b01,8'h59,8'h00,2'b01, 1,1,8'h59, -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,8'h5A,8'h00,2'b01, 2,1,8'h5A, -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,8'h5B,8'h00,2'b01, 4,1,8'h5B, -1,0,8'h00, 8'h00,0,0));
    vq.push_back(mk(1,1,2'b00,8'h00,8'h00,2'b00, -1,0,8'h00, -1,0,8'h00, 8'h00,0,0));
    // Stride-N fill of the even banks until full, then an overflowing request
    for (int i = 0; i < 16; i++) begin
      case (i)
        12:      fu = 8'h01;
        13:      fu = 8'h05;
        14:      fu = 8'h15;
        15:      fu = 8'h55;
        default: fu = 8'h00;
      endcase
      vq.push_back(mk(0,1,2'b01,8'(8'h80+i),8'h00,2'b01, (2*i)%8,i/4,8'(8'h80+i), -1,0,8'h00, fu,0,0));
    end
    vq.push_back(mk(0,1,2'b01,8'h90,8'h00,2'b00, -1,0,8'h00, -1,0,8'h00, 8'h55,0,1));

    for (int b = 0; b < N_BANK; b++) begin sh_addr[b] = '0; sh_din[b] = '0; end

    #1 r_reset_n = 1'b0;
    #1 chk_zero("async_reset", 0);
    repeat (2) @(posedge clk);
    #1 chk_zero("reset", 0);
    @(negedge clk);
    r_reset_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i], i + 1);

    // Reset in the middle of a burst with clr and requests held high
    @(negedge clk);
    stride_mode = 1'b0; wr_req = 2'b11; wr_data = {8'hE1, 8'hE0};
    @(posedge clk);
    #1;
    chk("burst_we", 100, 64'(bank_we), 64'h02);
    chk("burst_din", 100, 64'(bank_din[15:8]), 64'hE1);
    chk("burst_ack", 100, 64'(wr_ack), 64'h2);
    #2;
    r_reset_n = 1'b0; clr = 1'b1;
    #1 chk_zero("mid_reset", 101);
    @(posedge clk);
    #1 chk_zero("in_reset", 102);
    @(negedge clk);
    r_reset_n = 1'b1;
    @(posedge clk);
    #1 chk_zero("clr_after_reset", 103);
    @(negedge clk);
    clr = 1'b0; wr_req = 2'b00;
    @(posedge clk);
    #1 chk("idle_we", 104, 64'(bank_we), 64'h0);
    @(negedge clk);
    wr_req = 2'b01; wr_data = {8'h00, 8'hF0};
    @(posedge clk);
    #1;
    chk("resume_ack", 105, 64'(wr_ack), 64'h1);
    chk("resume_we", 105, 64'(bank_we), 64'h01);
    chk("resume_addr", 105, 64'(bank_addr), 64'h0);
    chk("resume_din", 105, 64'(bank_din), 64'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
